// File: rtl/cu_control_channel_slice.sv
// Multi-channel register slice plus first-word-fall-through elastic buffer.
// Each channel: non-stalling retiming stages, a credit-protected FIFO, sticky overflow status.
module cu_control_channel_slice #(
  parameter int NUM_CHANNELS  = 4,
  parameter int PAYLOAD_WIDTH = 512,
  parameter int PIPE_STAGES   = 2,
  parameter int FIFO_DEPTH    = 8,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1,
  localparam int SW = CW + 2
) (
  input  logic                                  clock,
  input  logic                                  rst_in,
  input  logic                                  enabled_in,
  input  logic [NUM_CHANNELS-1:0]               in_valid,
  input  logic [NUM_CHANNELS*PAYLOAD_WIDTH-1:0] in_payload,
  output logic [NUM_CHANNELS-1:0]               in_stall,
  output logic [NUM_CHANNELS-1:0]               out_valid,
  output logic [NUM_CHANNELS*PAYLOAD_WIDTH-1:0] out_payload,
  input  logic [NUM_CHANNELS-1:0]               out_ready,
  input  logic                                  clear_status_in,
  output logic [NUM_CHANNELS-1:0]               overflow_sticky,
  output logic [NUM_CHANNELS*CW-1:0]            fifo_count,
  output logic                                  drained
);

  logic [1:0] r_rst_sync;
  logic       w_rst;
  logic       r_enabled_q;
  logic [NUM_CHANNELS-1:0] w_busy;

  // Asserts with rst_in, releases two edges after rst_in falls.
  always_ff @(posedge clock or posedge rst_in) begin
    if (rst_in) r_rst_sync <= 2'b11;
    else        r_rst_sync <= {r_rst_sync[0], 1'b0};
  end

  assign w_rst = r_rst_sync[1];

  always_ff @(posedge clock or posedge w_rst) begin
    if (w_rst) r_enabled_q <= 1'b0;
    else       r_enabled_q <= enabled_in;
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic [PIPE_STAGES-1:0]   r_stage_vld;
    logic [PAYLOAD_WIDTH-1:0] r_stage_pl [PIPE_STAGES];
    logic [PAYLOAD_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]            r_wr_ptr;
    logic [AW-1:0]            r_rd_ptr;
    logic [CW-1:0]            r_count;
    logic                     r_ovf;
    logic                     w_empty;
    logic                     w_full;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_wr_en;
    logic                     w_ovf_now;
    logic                     w_out_valid;
    logic [SW-1:0]            w_credit_used;

    always_ff @(posedge clock or posedge w_rst) begin
      if (w_rst) begin
        r_stage_vld <= '0;
      end else begin
        r_stage_vld[0] <= in_valid[c];
        for (int k = 1; k < PIPE_STAGES; k++) r_stage_vld[k] <= r_stage_vld[k-1];
      end
    end

    always_ff @(posedge clock) begin
      r_stage_pl[0] <= in_payload[c*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
      for (int k = 1; k < PIPE_STAGES; k++) r_stage_pl[k] <= r_stage_pl[k-1];
    end

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_out_valid = ~w_empty & r_enabled_q;
    assign w_push      = r_stage_vld[PIPE_STAGES-1];
    assign w_pop       = w_out_valid & out_ready[c];
    // A full FIFO still takes a beat when the head leaves on the same edge.
    assign w_wr_en     = w_push & (~w_full | w_pop);
    assign w_ovf_now   = w_push & w_full & ~w_pop;

    always_ff @(posedge clock or posedge w_rst) begin
      if (w_rst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
        case ({w_wr_en, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end

    always_ff @(posedge clock) begin
      if (w_wr_en) r_mem[r_wr_ptr] <= r_stage_pl[PIPE_STAGES-1];
    end

    // A clear coinciding with a fresh overflow leaves the bit set.
    always_ff @(posedge clock or posedge w_rst) begin
      if (w_rst)                r_ovf <= 1'b0;
      else if (clear_status_in) r_ovf <= w_ovf_now;
      else if (w_ovf_now)       r_ovf <= 1'b1;
    end

    // Credit counts every beat already committed to this channel.
    always_comb begin
      w_credit_used = SW'(r_count);
      for (int k = 0; k < PIPE_STAGES; k++) begin
        w_credit_used = w_credit_used + SW'(r_stage_vld[k]);
      end
    end

    assign in_stall[c]                                    = (w_credit_used >= SW'(FIFO_DEPTH));
    assign out_valid[c]                                   = w_out_valid;
    assign out_payload[c*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]  = r_mem[r_rd_ptr];
    assign overflow_sticky[c]                             = r_ovf;
    assign fifo_count[c*CW +: CW]                         = r_count;
    assign w_busy[c]                                      = (|r_stage_vld) | ~w_empty;
  end

  assign drained = ~(|w_busy);

endmodule

// File: doc/cu_control_channel_slice.md
# cu_control_channel_slice

Parametrised multi-channel register slice and elastic buffer. It sits between the compute-unit clusters and the CAPI command/data buffers, in the position a fixed-channel cu_control latch stage would occupy. Each of NUM_CHANNELS independent channels gets the following, all under one registered enable:

- PIPE_STAGES of non-stalling retiming registers;
- a FIFO_DEPTH first-word-fall-through buffer with ready backpressure;
- credit-exact upstream stall, sticky overflow detection and a global drained indication.

## Interface
- NUM_CHANNELS, 4, number of independent valid/payload channels (1..16)
- PAYLOAD_WIDTH, 512, payload bits per channel
- PIPE_STAGES, 2, retiming register stages per channel before the FIFO (1..4)
- FIFO_DEPTH, 8, entries per channel FIFO; power of two, ≥ 2
- clock  in  1  single clock, all logic rising-edge
- rst_in  in  1  reset, asynchronous assert, active-high; deassertion synchronised internally
- enabled_in  in  1  global enable, registered once internally (enabled_q)
- in_valid  in  NUM_CHANNELS  per-channel input valid, no ready; accepted every asserted cycle
- in_payload  in  NUM_CHANNELS*PAYLOAD_WIDTH  channel c at bits [c*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]
- in_stall  out  NUM_CHANNELS  per-channel credit exhausted; upstream must not assert in_valid[c] while in_stall[c]=1
- out_valid  out  NUM_CHANNELS  FIFO head valid and enabled_q
- out_payload  out  NUM_CHANNELS*PAYLOAD_WIDTH  FIFO head data, same packing as in_payload
- out_ready  in  NUM_CHANNELS  downstream accept
- clear_status_in  in  1  clears overflow_sticky
- overflow_sticky  out  NUM_CHANNELS  set when a beat reached a full FIFO with no same-cycle pop
- fifo_count  out  NUM_CHANNELS*($clog2(FIFO_DEPTH)+1)  per-channel FIFO occupancy
- drained  out  1  all stage valids clear and all FIFOs empty

## Operation
- Reset:
  - rst_in=1 asynchronously clears all stage valids, FIFO pointers/counts, overflow_sticky, enabled_q and the 2-flop reset synchroniser.
  - Stage payloads and FIFO storage are not reset.
- Reset values and internal reset:
  - Outputs under reset: out_valid=0, in_stall=0, overflow_sticky=0, fifo_count=0, drained=1, out_payload don't-care.
  - Internal reset releases on the 2nd rising edge after rst_in falls.
  - enabled_q follows enabled_in one edge later.
- Pipeline:
  - Stage k valid/payload loads from stage k-1 every edge, unconditionally; it never stalls.
  - Stage 0 loads from in_valid/in_payload.
  - The last stage writes into the FIFO when its valid is set.
- Push/pop:
  - push = last-stage valid.
  - pop = out_valid & out_ready, where out_valid = ~empty & enabled_q.
  - Push and pop in the same cycle: count is unchanged; a push into a full FIFO is legal if pop is also asserted.
  - Push with count==FIFO_DEPTH and no pop: the beat is dropped, overflow_sticky[c] is set and pointers are unchanged.
  - Read/write pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
- Credit: in_stall[c] = (fifo_count[c] + valid stages of c) ≥ FIFO_DEPTH.
  - It is a combinational function of registers only; there is no path from in_valid or out_ready.
  - An upstream that obeys in_stall can never cause overflow.
- Enable low:
  - out_valid is forced 0 and no pops occur.
  - Pipeline and FIFO keep accepting and filling, and in_stall still protects them.
  - Contents are preserved and resume when enabled_q returns to 1.
- Status:
  - clear_status_in clears all overflow_sticky bits at the next edge.
  - A simultaneous overflow on channel c wins: the bit stays set.
- drained = NOR of every stage valid and every FIFO non-empty flag, decoded from registers.

## Timing
- Latency: in_valid at edge E → FIFO write at edge E+PIPE_STAGES → out_valid high in the cycle after E+PIPE_STAGES, i.e. PIPE_STAGES+1 cycles. The default is 3.
- Throughput: 1 beat/cycle/channel while out_ready stays high.
- out_valid/out_payload change only on edges. The head updates on the edge that pops.
- enabled_in → out_valid effect: 1 cycle.
- in_stall reflects a pop on the following cycle. It deasserts one cycle after a pop from full.

## Test plan
- Reset latency:
  - Stimulus: release rst_in, then assert in_valid[0] with payload 0xA5 at cycle 3.
  - Required: out_valid[0]=1 with payload 0xA5 exactly 3 cycles later; fifo_count[0]=1; drained=0.
- Back-to-back streaming:
  - Stimulus: 100 consecutive beats on all 4 channels, out_ready=1, distinct per-channel sequences.
  - Required: in-order output; zero bubbles after fill; drained=1 at the end.
- Backpressure fill:
  - Stimulus: out_ready[2]=0; drive channel 2 only while in_stall[2]=0.
  - Required: exactly 8 beats accepted; in_stall[2]=1; fifo_count[2]=8 after the pipeline drains; no overflow.
  - Follow-up: pulse out_ready for one cycle. Required: count 7, then in_stall=0 on the next cycle.
- Overflow:
  - Stimulus: ignore in_stall, push 10 beats with out_ready=0.
  - Required: overflow_sticky[1]=1; count=8; the first 8 payloads are retained.
  - Follow-up: clear_status_in together with another overflow. Required: the bit stays 1; a clear alone then gives 0.
- Enable gating:
  - Stimulus: enabled_in=0 with 3 beats buffered.
  - Required: out_valid=0 and count holds at 3.
  - Follow-up: re-enable. Required: the 3 beats appear in order 1 cycle later.
- Mid-operation reset:
  - Stimulus: assert rst_in with FIFOs half full.
  - Required: immediately out_valid=0, fifo_count=0, drained=1; no stale beat after release.
